fe_fetch_queue: RTL and testbench

- Parametrised front-end fetch stage: PC generation, instruction-memory addressing and a QUEUE_DEPTH_P-entry fetch queue.
- Decouples fetch from decode with a valid/ready handshake, so fetch does not stall when decode back-pressures for a few cycles.
- Accepts two redirect sources: backend mispredict (highest priority) and decode/branch-stage redirect.
- Sits between the instruction ROM and the decode pipe register.

---
 rtl/fe_fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fe_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_fetch_queue.sv
// Front-end fetch stage: PC generation, instruction-ROM addressing and a
// QUEUE_DEPTH_P-entry fetch queue with a valid/ready interface to decode.
// Backend mispredict beats front-end redirect; either one flushes the queue.
// Optional return address stack is built when FE_RAS_EN is defined.
module fe_fetch_queue #(
  parameter int WORD_SIZE_P   = 16,
  parameter int ADDR_WIDTH_P  = 16,
  parameter int QUEUE_DEPTH_P = 4,
  parameter int RESET_PC_P    = 0,
  parameter int RAS_DEPTH_P   = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             mis_predict_i,
  input  logic [WORD_SIZE_P-1:0]           mis_target_i,
  input  logic                             redirect_v_i,
  input  logic [WORD_SIZE_P-1:0]           redirect_target_i,
  output logic [ADDR_WIDTH_P-1:0]          imem_addr_o,
  input  logic [WORD_SIZE_P-1:0]           imem_data_i,
  input  logic                             ready_i,
  output logic                             valid_o,
  output logic [WORD_SIZE_P-1:0]           pc_o,
  output logic [WORD_SIZE_P-1:0]           instr_o,
  output logic [$clog2(QUEUE_DEPTH_P+1)-1:0] occupancy_o,
  input  logic                             call_v_i,
  input  logic [WORD_SIZE_P-1:0]           call_ret_pc_i,
  input  logic                             ret_v_i,
  output logic [WORD_SIZE_P-1:0]           ras_target_o,
  output logic                             ras_valid_o
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH_P);
  localparam int CNT_W = $clog2(QUEUE_DEPTH_P+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH_P);

  logic [WORD_SIZE_P-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [2*WORD_SIZE_P-1:0] mem_q [QUEUE_DEPTH_P];
  logic                     flush, deq, enq;

  assign imem_addr_o      = pc_q[ADDR_WIDTH_P-1:0];
  assign {pc_o, instr_o}  = mem_q[head_q];
  assign occupancy_o      = cnt_q;

  // Next-state for PC and queue pointers: mispredict > redirect > enq/deq
  always_comb begin
    flush   = mis_predict_i | redirect_v_i;
    valid_o = (cnt_q != '0) & ~flush;
    deq     = valid_o & ready_i;
    enq     = 1'b0;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (mis_predict_i) begin
      pc_d   = mis_target_i;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else if (redirect_v_i) begin
      pc_d   = redirect_target_i;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      // A full queue may still accept when the head leaves this cycle
      enq = (cnt_q < DEPTH_C) | deq;
      if (enq) begin
        tail_d = tail_q + PTR_W'(1);
        pc_d   = pc_q + WORD_SIZE_P'(1);
      end
      if (deq) head_d = head_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // PC and queue control state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q   <= WORD_SIZE_P'(RESET_PC_P);
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Queue payload; data entries need no reset since count gates validity
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[tail_q] <= {pc_q, imem_data_i};
  end

`ifdef FE_RAS_EN
  localparam int RP_W = $clog2(RAS_DEPTH_P);
  localparam int RC_W = $clog2(RAS_DEPTH_P+1);
  localparam logic [RC_W-1:0] RAS_DEPTH_C = RC_W'(RAS_DEPTH_P);

  logic [WORD_SIZE_P-1:0] ras_mem_q [RAS_DEPTH_P];
  logic [RP_W-1:0]        ras_top_q, ras_top_d, ras_waddr;
  logic [RC_W-1:0]        ras_cnt_q, ras_cnt_d;
  logic                   ras_we;

  assign ras_valid_o  = (ras_cnt_q != '0);
  assign ras_target_o = ras_valid_o ? ras_mem_q[ras_top_q] : '0;

  // Circular stack: pushing when full overwrites the oldest slot
  always_comb begin
    ras_top_d = ras_top_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ras_top_q;
    if (mis_predict_i) begin
      ras_top_d = '0;
      ras_cnt_d = '0;
    end else if (call_v_i & ret_v_i) begin
      ras_we = 1'b1;
    end else if (call_v_i) begin
      ras_we    = 1'b1;
      ras_waddr = ras_top_q + RP_W'(1);
      ras_top_d = ras_waddr;
      if (ras_cnt_q != RAS_DEPTH_C) ras_cnt_d = ras_cnt_q + RC_W'(1);
    end else if (ret_v_i & ras_valid_o) begin
      ras_top_d = ras_top_q - RP_W'(1);
      ras_cnt_d = ras_cnt_q - RC_W'(1);
    end
  end

  // RAS pointer and count
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ras_top_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // RAS storage
  always_ff @(posedge clk_i) begin
    if (ras_we) ras_mem_q[ras_waddr] <= call_ret_pc_i;
  end
`else
  logic unused_ras;
  assign unused_ras   = ^{call_v_i, ret_v_i, call_ret_pc_i};
  assign ras_target_o = '0;
  assign ras_valid_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fe_fetch_queue.sv
// Self-checking bench for fe_fetch_queue: directed scenarios plus a random
// run scored against a queue/stack reference model.
module tb_fe_fetch_queue;
  logic        clk_i = 1'b0, reset_i = 1'b1;
  logic        mis_predict_i, redirect_v_i, ready_i, call_v_i, ret_v_i;
  logic [15:0] mis_target_i, redirect_target_i, call_ret_pc_i;
  logic [15:0] imem_addr_o, imem_data_i, pc_o, instr_o, ras_target_o;
  logic        valid_o, ras_valid_o;
  logic [2:0]  occupancy_o;

  int n_cmp = 0, n_err = 0;

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  assign imem_data_i = rom(imem_addr_o);

  fe_fetch_queue dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mis_predict_i(mis_predict_i), .mis_target_i(mis_target_i),
    .redirect_v_i(redirect_v_i), .redirect_target_i(redirect_target_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o),
    .occupancy_o(occupancy_o),
    .call_v_i(call_v_i), .call_ret_pc_i(call_ret_pc_i), .ret_v_i(ret_v_i),
    .ras_target_o(ras_target_o), .ras_valid_o(ras_valid_o)
  );

  // Reference model: PCs waiting in the queue, fetch PC, and return stack
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic [15:0] m_ras[$];

  task automatic m_reset();
    m_pc = 16'h0000;
    m_q.delete();
    m_ras.delete();
  endtask

  function automatic bit m_vld();
    return (m_q.size() != 0) && !(mis_predict_i || redirect_v_i);
  endfunction

  function automatic logic [15:0] m_ras_top();
    return (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 16'h0000;
  endfunction

  // Advance the model with the current inputs, then clock the DUT
  task automatic m_tick();
    int sz = m_q.size();
    bit dq = m_vld() && ready_i;
    if (mis_predict_i) begin
      m_pc = mis_target_i; m_q.delete();
    end else if (redirect_v_i) begin
      m_pc = redirect_target_i; m_q.delete();
    end else begin
      if (dq) void'(m_q.pop_front());
      if (sz < 4 || dq) begin m_q.push_back(m_pc); m_pc = m_pc + 16'd1; end
    end
`ifdef FE_RAS_EN
    if (mis_predict_i) m_ras.delete();
    else if (call_v_i && ret_v_i) begin
      if (m_ras.size() != 0) m_ras[m_ras.size()-1] = call_ret_pc_i;
    end else if (call_v_i) begin
      m_ras.push_back(call_ret_pc_i);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (ret_v_i && m_ras.size() != 0) void'(m_ras.pop_back());
`endif
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    mis_predict_i = 0; redirect_v_i = 0; ready_i = 0; call_v_i = 0; ret_v_i = 0;
    mis_target_i = 0; redirect_target_i = 0; call_ret_pc_i = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1;
    @(negedge clk_i); @(negedge clk_i);
    reset_i = 0;
    m_reset();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_i = 1;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (occupancy_o !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    n_cmp++; if (imem_addr_o !== 16'h0000) begin n_err++; $display("FAIL reset_addr: got %h want 0000", imem_addr_o); end
    n_cmp++; if (ras_valid_o !== 1'b0 || ras_target_o !== 16'h0000) begin
      n_err++; $display("FAIL reset_ras: got %b/%h want 0/0000", ras_valid_o, ras_target_o); end
  endtask

  task automatic test_free_run();
    do_reset();
    ready_i = 1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL free_first_valid: got %b want 0", valid_o); end
    m_tick();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (valid_o !== 1'b1 || pc_o !== 16'(i) || instr_o !== rom(16'(i))) begin
        n_err++; $display("FAIL free_run[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                          i, valid_o, pc_o, instr_o, 16'(i), rom(16'(i))); end
      m_tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) m_tick();
    n_cmp++; if (occupancy_o !== 3'd4) begin n_err++; $display("FAIL bp_occ: got %0d want 4", occupancy_o); end
    n_cmp++; if (imem_addr_o !== 16'h0004) begin n_err++; $display("FAIL bp_pc: got %h want 0004", imem_addr_o); end
    ready_i = 1;
    #1;
    // Full queue streaming: one per cycle, pointers wrap several times
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (valid_o !== 1'b1 || pc_o !== 16'(i) || instr_o !== rom(16'(i)) || occupancy_o !== 3'd4) begin
        n_err++; $display("FAIL bp_stream[%0d]: got v=%b pc=%h ins=%h occ=%0d want v=1 pc=%h ins=%h occ=4",
                          i, valid_o, pc_o, instr_o, occupancy_o, 16'(i), rom(16'(i))); end
      m_tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) m_tick();
    n_cmp++; if (occupancy_o !== 3'd3) begin n_err++; $display("FAIL redir_pre_occ: got %0d want 3", occupancy_o); end
    ready_i = 1; redirect_v_i = 1; redirect_target_i = 16'h0040;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b want 0", valid_o); end
    m_tick();
    redirect_v_i = 0;
    #1;
    n_cmp++; if (occupancy_o !== 3'd0 || valid_o !== 1'b0) begin
      n_err++; $display("FAIL redir_flush: got occ=%0d v=%b want 0/0", occupancy_o, valid_o); end
    m_tick();
    n_cmp++; if (valid_o !== 1'b1 || pc_o !== 16'h0040) begin
      n_err++; $display("FAIL redir_target: got v=%b pc=%h want 1/0040", valid_o, pc_o); end
  endtask

  task automatic test_mispredict_priority();
    do_reset();
    m_tick(); m_tick();
    ready_i = 1; mis_predict_i = 1; mis_target_i = 16'h0100;
    redirect_v_i = 1; redirect_target_i = 16'h0040;
    m_tick();
    mis_predict_i = 0; redirect_v_i = 0;
    m_tick();
    n_cmp++; if (valid_o !== 1'b1 || pc_o !== 16'h0100 || instr_o !== rom(16'h0100)) begin
      n_err++; $display("FAIL mis_prio: got v=%b pc=%h ins=%h want 1/0100/%h", valid_o, pc_o, instr_o, rom(16'h0100)); end
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    call_v_i = 1; call_ret_pc_i = 16'h0ABC;
    m_tick();
    call_v_i = 0;
    m_tick();
    redirect_v_i = 1; redirect_target_i = 16'h0040;
    #2;
    reset_i = 1;
    #1;
    n_cmp++; if (occupancy_o !== 3'd0 || valid_o !== 1'b0 || imem_addr_o !== 16'h0000 ||
                 ras_valid_o !== 1'b0 || ras_target_o !== 16'h0000) begin
      n_err++; $display("FAIL mid_reset: got occ=%0d v=%b addr=%h rv=%b rt=%h want 0/0/0000/0/0000",
                        occupancy_o, valid_o, imem_addr_o, ras_valid_o, ras_target_o); end
    idle();
    @(negedge clk_i);
    reset_i = 0;
    m_reset();
    #1;
  endtask

  task automatic test_ras();
`ifdef FE_RAS_EN
    logic [15:0] pops [3] = '{16'h0040, 16'h0030, 16'h0020};
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      call_v_i = 1; call_ret_pc_i = 16'(i * 16);
      m_tick();
    end
    call_v_i = 0;
    n_cmp++; if (ras_valid_o !== 1'b1 || ras_target_o !== 16'h0050) begin
      n_err++; $display("FAIL ras_push: got %b/%h want 1/0050", ras_valid_o, ras_target_o); end
    ret_v_i = 1;
    for (int i = 0; i < 3; i++) begin
      m_tick();
      n_cmp++; if (ras_valid_o !== 1'b1 || ras_target_o !== pops[i]) begin
        n_err++; $display("FAIL ras_pop[%0d]: got %b/%h want 1/%h", i, ras_valid_o, ras_target_o, pops[i]); end
    end
    m_tick();
    m_tick();
    ret_v_i = 0;
    n_cmp++; if (ras_valid_o !== 1'b0 || ras_target_o !== 16'h0000) begin
      n_err++; $display("FAIL ras_empty: got %b/%h want 0/0000", ras_valid_o, ras_target_o); end
    call_v_i = 1; call_ret_pc_i = 16'h0060; m_tick();
    call_ret_pc_i = 16'h0070; m_tick();
    ret_v_i = 1; call_ret_pc_i = 16'h0099; m_tick();
    call_v_i = 0;
    n_cmp++; if (ras_target_o !== 16'h0099) begin n_err++; $display("FAIL ras_replace: got %h want 0099", ras_target_o); end
    m_tick();
    ret_v_i = 0;
    n_cmp++; if (ras_valid_o !== 1'b1 || ras_target_o !== 16'h0060) begin
      n_err++; $display("FAIL ras_replace_cnt: got %b/%h want 1/0060", ras_valid_o, ras_target_o); end
    mis_predict_i = 1; call_v_i = 1; call_ret_pc_i = 16'h0777;
    m_tick();
    mis_predict_i = 0; call_v_i = 0;
    n_cmp++; if (ras_valid_o !== 1'b0) begin n_err++; $display("FAIL ras_mis_clear: got %b want 0", ras_valid_o); end
`else
    do_reset();
    call_v_i = 1; call_ret_pc_i = 16'h1234;
    m_tick(); m_tick();
    call_v_i = 0;
    n_cmp++; if (ras_valid_o !== 1'b0 || ras_target_o !== 16'h0000) begin
      n_err++; $display("FAIL ras_absent: got %b/%h want 0/0000", ras_valid_o, ras_target_o); end
`endif
  endtask

  task automatic test_random();
    bit ev;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int r = $urandom_range(0, 99);
      ready_i           = ($urandom_range(0, 9) < 7);
      mis_predict_i     = (r < 3);
      redirect_v_i      = (r >= 3 && r < 8);
      mis_target_i      = 16'($urandom);
      redirect_target_i = 16'($urandom);
      call_v_i          = ($urandom_range(0, 4) == 0);
      ret_v_i           = ($urandom_range(0, 4) == 0);
      call_ret_pc_i     = 16'($urandom);
      #1;
      ev = m_vld();
      n_cmp++; if (valid_o !== ev) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", c, valid_o, ev); end
      n_cmp++; if (occupancy_o !== 3'(m_q.size())) begin
        n_err++; $display("FAIL rnd_occ@%0d: got %0d want %0d", c, occupancy_o, m_q.size()); end
      n_cmp++; if (imem_addr_o !== m_pc) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", c, imem_addr_o, m_pc); end
      if (m_q.size() != 0) begin
        n_cmp++; if (pc_o !== m_q[0] || instr_o !== rom(m_q[0])) begin
          n_err++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", c, pc_o, instr_o, m_q[0], rom(m_q[0])); end
      end
      n_cmp++; if (ras_valid_o !== (m_ras.size() != 0) || ras_target_o !== m_ras_top()) begin
        n_err++; $display("FAIL rnd_ras@%0d: got %b/%h want %b/%h", c, ras_valid_o, ras_target_o,
                          (m_ras.size() != 0), m_ras_top()); end
      m_tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_mispredict_priority();
    test_reset_mid_redirect();
    test_ras();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
